// File: rtl/axilite_adder_master.sv
`timescale 1ns/1ps
// AXI4-Lite initiator for the memory-mapped adder: writes A and B, reads back
// the sum and overflow mask, and reports result/error status locally.
module axilite_adder_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASEADDR  = '0,
  parameter int                            TIMEOUT_CYCLES     = 256
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     op_a,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     op_b,
  output logic                              busy,
  output logic                              done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     sum,
  output logic                              ovf,
  output logic                              err,
  output logic [1:0]                        err_stage,
  output logic                              err_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_BW, S_RA, S_RD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d, sum_rd_q, sum_rd_d, sum_q, sum_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            ovf_q, ovf_d, err_q, err_d, err_timeout_q, err_timeout_d;
  logic [1:0]      err_stage_q, err_stage_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [AW-1:0]   reg_addr;
  logic            aw_hs, w_hs, tmo_hit, abort, abort_tmo;

  // Transaction index doubles as the register word offset (A, B, SUM, OVF).
  assign reg_addr      = C_TARGET_BASEADDR + AW'({idx_q, 2'b00});
  assign M_AXI_AWADDR  = reg_addr;
  assign M_AXI_ARADDR  = reg_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WDATA   = idx_q[0] ? b_q : a_q;
  assign M_AXI_AWVALID = (state_q == S_WR) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == S_WR) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == S_BW);
  assign M_AXI_ARVALID = (state_q == S_RA);
  assign M_AXI_RREADY  = (state_q == S_RD);

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign sum         = sum_q;
  assign ovf         = ovf_q;
  assign err         = err_q;
  assign err_stage   = err_stage_q;
  assign err_timeout = err_timeout_q;

  assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    a_d           = a_q;
    b_d           = b_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    sum_rd_d      = sum_rd_q;
    sum_d         = sum_q;
    ovf_d         = ovf_q;
    err_d         = err_q;
    err_stage_d   = err_stage_q;
    err_timeout_d = err_timeout_q;
    abort         = 1'b0;
    abort_tmo     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        a_d       = op_a;
        b_d       = op_b;
        idx_d     = 2'd0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = S_WR;
      end
      S_WR: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_BW;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
          if (tmo_hit) begin abort = 1'b1; abort_tmo = 1'b1; end
        end
      end
      S_BW: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP == 2'b00) begin
            idx_d   = idx_q + 2'd1;
            state_d = idx_q[0] ? S_RA : S_WR;
          end else abort = 1'b1;
        end else if (tmo_hit) begin abort = 1'b1; abort_tmo = 1'b1; end
      end
      S_RA: begin
        if (M_AXI_ARREADY) state_d = S_RD;
        else if (tmo_hit) begin abort = 1'b1; abort_tmo = 1'b1; end
      end
      S_RD: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) abort = 1'b1;
          else if (!idx_q[0]) begin
            sum_rd_d = M_AXI_RDATA;
            idx_d    = idx_q + 2'd1;
            state_d  = S_RA;
          end else begin
            // Results are published only at completion so they stay stable between done pulses.
            sum_d         = sum_rd_q;
            ovf_d         = |M_AXI_RDATA;
            err_d         = 1'b0;
            err_stage_d   = 2'd0;
            err_timeout_d = 1'b0;
            state_d       = S_DONE;
          end
        end else if (tmo_hit) begin abort = 1'b1; abort_tmo = 1'b1; end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d       = S_DONE;
      err_d         = 1'b1;
      err_stage_d   = idx_q;
      err_timeout_d = abort_tmo;
      aw_done_d     = 1'b0;
      w_done_d      = 1'b0;
    end
    // Phase counter restarts on every state change and saturates otherwise.
    if ((state_d != state_q) || (state_q == S_IDLE)) tmo_cnt_d = '0;
    else if (tmo_cnt_q != TMO_LAST)                  tmo_cnt_d = tmo_cnt_q + 1'b1;
    else                                             tmo_cnt_d = tmo_cnt_q;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      sum_rd_q      <= '0;
      sum_q         <= '0;
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
      err_stage_q   <= '0;
      err_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      a_q           <= a_d;
      b_q           <= b_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      sum_rd_q      <= sum_rd_d;
      sum_q         <= sum_d;
      ovf_q         <= ovf_d;
      err_q         <= err_d;
      err_stage_q   <= err_stage_d;
      err_timeout_q <= err_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end
endmodule

// File: tb/tb_axilite_adder_master.sv
`timescale 1ns/1ps
// Bench for axilite_adder_master: two instances (base 0 / timeout 16 and
// base 0x40000000 / default timeout) share one behavioural adder slave.
module tb_axilite_adder_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, start;
  logic [31:0] op_a, op_b;
  int vecs = 0, errs = 0;

  logic        busy_m [2], done_m [2], ovf_m [2], err_m [2], errt_m [2];
  logic [1:0]  errs_m [2];
  logic [31:0] sum_m [2], awaddr_m [2], wdata_m [2], araddr_m [2];
  logic [2:0]  awprot_m [2], arprot_m [2];
  logic [3:0]  wstrb_m [2];
  logic        awvalid_m [2], wvalid_m [2], bready_m [2], arvalid_m [2], rready_m [2];

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axilite_adder_master #(
      .C_TARGET_BASEADDR(g ? 32'h4000_0000 : 32'h0),
      .TIMEOUT_CYCLES(g ? 256 : 16)
    ) u_dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .start(start && (sel == 1'(g))), .op_a(op_a), .op_b(op_b),
      .busy(busy_m[g]), .done(done_m[g]), .sum(sum_m[g]), .ovf(ovf_m[g]),
      .err(err_m[g]), .err_stage(errs_m[g]), .err_timeout(errt_m[g]),
      .M_AXI_AWADDR(awaddr_m[g]), .M_AXI_AWPROT(awprot_m[g]), .M_AXI_AWVALID(awvalid_m[g]),
      .M_AXI_AWREADY(awready && (sel == 1'(g))),
      .M_AXI_WDATA(wdata_m[g]), .M_AXI_WSTRB(wstrb_m[g]), .M_AXI_WVALID(wvalid_m[g]),
      .M_AXI_WREADY(wready && (sel == 1'(g))),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid && (sel == 1'(g))), .M_AXI_BREADY(bready_m[g]),
      .M_AXI_ARADDR(araddr_m[g]), .M_AXI_ARPROT(arprot_m[g]), .M_AXI_ARVALID(arvalid_m[g]),
      .M_AXI_ARREADY(arready && (sel == 1'(g))),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid && (sel == 1'(g))),
      .M_AXI_RREADY(rready_m[g])
    );
  end

  // View of the selected instance
  logic        busy, done, ovf, err, err_timeout, awvalid, wvalid, bready, arvalid, rready;
  logic [1:0]  err_stage;
  logic [31:0] sum, awaddr, wdata, araddr;
  always_comb begin
    busy = busy_m[sel]; done = done_m[sel]; ovf = ovf_m[sel]; err = err_m[sel];
    err_timeout = errt_m[sel]; err_stage = errs_m[sel]; sum = sum_m[sel];
    awvalid = awvalid_m[sel]; wvalid = wvalid_m[sel]; bready = bready_m[sel];
    arvalid = arvalid_m[sel]; rready = rready_m[sel];
    awaddr = awaddr_m[sel]; wdata = wdata_m[sel]; araddr = araddr_m[sel];
  end

  // Behavioural adder slave: response one idle cycle after the address/data handshake
  int          aw_delay;
  bit          b_err_on_b, ar_block;
  int          aw_wait;
  logic        aw_got, w_got, b_arm, b_is_b, r_arm, aw_now, w_now;
  logic [31:0] aw_addr_l, w_data_l, r_addr_l, ra, rb, aw_cur, w_cur, add_w, ovf_word;
  logic [32:0] log_q [$];

  assign awready  = awvalid && (aw_wait >= aw_delay);
  assign wready   = 1'b1;
  assign arready  = arvalid && !ar_block;
  assign aw_now   = aw_got || (awvalid && awready);
  assign w_now    = w_got || (wvalid && wready);
  assign aw_cur   = aw_got ? aw_addr_l : awaddr;
  assign w_cur    = w_got ? w_data_l : wdata;
  assign add_w    = ra + rb;
  assign ovf_word = ((ra[31] == rb[31]) && (add_w[31] != ra[31])) ? 32'hFFFF_FFFF : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 0; w_got <= 0; b_arm <= 0; b_is_b <= 0; bvalid <= 0; bresp <= 0;
      r_arm <= 0; rvalid <= 0; rresp <= 0; rdata <= 0; aw_wait <= 0;
      aw_addr_l <= 0; w_data_l <= 0; r_addr_l <= 0; ra <= 0; rb <= 0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1; aw_addr_l <= awaddr; log_q.push_back({1'b0, awaddr}); end
      if (wvalid && wready) begin w_got <= 1; w_data_l <= wdata; end
      if (aw_now && w_now) begin
        aw_got <= 0; w_got <= 0; b_arm <= 1; b_is_b <= (aw_cur[3:0] == 4'h4);
        if (aw_cur[3:0] == 4'h0) ra <= w_cur;
        if (aw_cur[3:0] == 4'h4) rb <= w_cur;
      end
      if (b_arm) begin
        b_arm <= 0; bvalid <= 1; bresp <= (b_err_on_b && b_is_b) ? 2'b10 : 2'b00;
      end
      if (bvalid && bready) bvalid <= 0;
      if (arvalid && arready) begin r_arm <= 1; r_addr_l <= araddr; log_q.push_back({1'b1, araddr}); end
      if (r_arm) begin
        r_arm <= 0; rvalid <= 1; rresp <= 2'b00;
        rdata <= (r_addr_l[3:0] == 4'h8) ? add_w : ((r_addr_l[3:0] == 4'hC) ? ovf_word : 32'h0);
      end
      if (rvalid && rready) rvalid <= 0;
    end
  end

  // Pulse start from a point #1 after an edge; returns edges until done is seen (cap 200).
  task automatic run_seq(input logic [31:0] a, input logic [31:0] b, output int lat, output logic busy1);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat = 1; busy1 = busy;
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 1'b0; op_a = '0; op_b = '0;
    aw_delay = 0; b_err_on_b = 0; ar_block = 0;
    repeat (3) @(posedge clk); #1;
    vecs++; if ({busy, done, err, ovf, err_timeout} !== 5'b0) begin errs++; $display("FAIL rst_flags got=%b exp=00000", {busy, done, err, ovf, err_timeout}); end
    vecs++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin errs++; $display("FAIL rst_axi got=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready}); end
    vecs++; if ({sum, err_stage} !== 34'h0) begin errs++; $display("FAIL rst_sum got=%h/%0d exp=0/0", sum, err_stage); end
    vecs++; if ({awprot_m[0], arprot_m[0], wstrb_m[0]} !== 10'b000_000_1111) begin errs++; $display("FAIL rst_const got=%b exp=0000001111", {awprot_m[0], arprot_m[0], wstrb_m[0]}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic b1; logic [32:0] exp [4];
    exp = '{33'h0_0000_0000, 33'h0_0000_0004, 33'h1_0000_0008, 33'h1_0000_000C};
    sel = 1'b0; log_q.delete();
    run_seq(32'd5, 32'd7, lat, b1);
    vecs++; if (lat !== 13) begin errs++; $display("FAIL t1_latency got=%0d exp=13", lat); end
    vecs++; if (b1 !== 1'b1) begin errs++; $display("FAIL t1_busy got=%b exp=1", b1); end
    vecs++; if ({sum, ovf, err, busy} !== {32'd12, 3'b000}) begin errs++; $display("FAIL t1_result got=%h/%b/%b/%b exp=0000000c/0/0/0", sum, ovf, err, busy); end
    vecs++; if (log_q.size() !== 4) begin errs++; $display("FAIL t1_log_size got=%0d exp=4", log_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      vecs++; if (log_q[i] !== exp[i]) begin errs++; $display("FAIL t1_order[%0d] got=%h exp=%h", i, log_q[i], exp[i]); end
    end
    @(posedge clk); #1;
    vecs++; if ({done, sum} !== {1'b0, 32'd12}) begin errs++; $display("FAIL t1_one_pulse got=%b/%h exp=0/0000000c", done, sum); end
  endtask

  task automatic test_ovf_base();
    int lat; logic b1;
    sel = 1'b1; log_q.delete();
    run_seq(32'h7FFF_FFFF, 32'd1, lat, b1);
    vecs++; if (lat !== 13) begin errs++; $display("FAIL t2_latency got=%0d exp=13", lat); end
    vecs++; if ({sum, ovf, err} !== {32'h8000_0000, 2'b10}) begin errs++; $display("FAIL t2_result got=%h/%b/%b exp=80000000/1/0", sum, ovf, err); end
    vecs++; if (log_q.size() !== 4) begin errs++; $display("FAIL t2_log_size got=%0d exp=4", log_q.size()); end
    else begin
      vecs++; if (log_q[0] !== 33'h0_4000_0000) begin errs++; $display("FAIL t2_addr_a got=%h exp=040000000", log_q[0]); end
      vecs++; if (log_q[3] !== 33'h1_4000_000C) begin errs++; $display("FAIL t2_addr_ovf got=%h exp=14000000c", log_q[3]); end
    end
    @(posedge clk); #1; sel = 1'b0;
  endtask

  task automatic test_aw_delay();
    int n;
    sel = 1'b0; aw_delay = 3;
    op_a = 32'd100; op_b = 32'd23; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    vecs++; if ({awvalid, wvalid} !== 2'b11) begin errs++; $display("FAIL t3_both_valid got=%b exp=11", {awvalid, wvalid}); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      vecs++; if ({awvalid, wvalid, awaddr} !== {2'b10, 32'h0}) begin errs++; $display("FAIL t3_hold[%0d] got=%b%b/%h exp=10/00000000", k, awvalid, wvalid, awaddr); end
    end
    @(posedge clk); #1;
    vecs++; if (awvalid !== 1'b0) begin errs++; $display("FAIL t3_aw_drop got=%b exp=0", awvalid); end
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    vecs++; if ({done, sum, err} !== {1'b1, 32'd123, 1'b0}) begin errs++; $display("FAIL t3_result got=%b/%h/%b exp=1/0000007b/0", done, sum, err); end
    aw_delay = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_bresp_err();
    int lat; logic b1;
    sel = 1'b0; b_err_on_b = 1; log_q.delete();
    run_seq(32'd1, 32'd2, lat, b1);
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL t4_done got=%b exp=1 after %0d cycles", done, lat); end
    vecs++; if ({err, err_stage, err_timeout} !== 4'b1_01_0) begin errs++; $display("FAIL t4_status got=%b/%0d/%b exp=1/1/0", err, err_stage, err_timeout); end
    vecs++; if (log_q.size() !== 2) begin errs++; $display("FAIL t4_no_ar got=%0d exp=2 transactions", log_q.size()); end
    b_err_on_b = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int n, ar_cycles;
    sel = 1'b0; ar_block = 1;
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0; ar_cycles = 0;
    while (done !== 1'b1 && n < 200) begin
      if (arvalid === 1'b1) ar_cycles++;
      @(posedge clk); #1; n++;
    end
    vecs++; if (ar_cycles !== 16) begin errs++; $display("FAIL t5_ar_cycles got=%0d exp=16", ar_cycles); end
    vecs++; if ({done, arvalid} !== 2'b10) begin errs++; $display("FAIL t5_ar_drop got=%b/%b exp=1/0", done, arvalid); end
    vecs++; if ({err, err_stage, err_timeout} !== 4'b1_10_1) begin errs++; $display("FAIL t5_status got=%b/%0d/%b exp=1/2/1", err, err_stage, err_timeout); end
    ar_block = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n;
    sel = 1'b0;
    op_a = 32'd3; op_b = 32'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (rready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    vecs++; if (rready !== 1'b1) begin errs++; $display("FAIL t6_reach_rd got=%b exp=1", rready); end
    rst = 1'b1;
    @(posedge clk); #1;
    vecs++; if ({awvalid, wvalid, arvalid, bready, rready, busy, done, err} !== 8'b0) begin errs++; $display("FAIL t6_reset got=%b exp=00000000", {awvalid, wvalid, arvalid, bready, rready, busy, done, err}); end
    rst = 1'b0; log_q.delete();
    @(posedge clk); #1;
    op_a = 32'd10; op_b = 32'd20; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; op_a = 32'hDEAD; n = 1;
    while (done !== 1'b1 && n < 200) begin
      start = (n == 3);
      @(posedge clk); #1; n++;
    end
    start = 1'b0;
    vecs++; if (n !== 13) begin errs++; $display("FAIL t6_latency got=%0d exp=13", n); end
    vecs++; if ({sum, err, ovf} !== {32'd30, 2'b00}) begin errs++; $display("FAIL t6_result got=%h/%b/%b exp=0000001e/0/0", sum, err, ovf); end
    vecs++; if (log_q.size() !== 4) begin errs++; $display("FAIL t6_log_size got=%0d exp=4", log_q.size()); end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    vecs++; if ({busy, awvalid} !== 2'b00) begin errs++; $display("FAIL t6_start_in_done got=%b%b exp=00", busy, awvalid); end
    @(posedge clk); #1;
    vecs++; if ({busy, awvalid, done} !== 3'b000) begin errs++; $display("FAIL t6_idle got=%b exp=000", {busy, awvalid, done}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf_base();
    test_aw_delay();
    test_bresp_err();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
